// File: rtl/ram_demap_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ram_demap_fifo                                                  |
// | Brief    : Single-clock RAM FIFO with registered read port, occupancy      |
// |            flags, synchronous flush and optional sticky error flags        |
// |            (enabled by defining RAM_DEMAP_FIFO_ERR_EN).                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ram_demap_fifo #(
  parameter int AD    = 14,
  parameter int DATA  = 1,
  parameter int AF_TH = 2**AD - 4,
  parameter int AE_TH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            we,
  input  logic [DATA-1:0] data_in,
  input  logic            re,
  output logic [DATA-1:0] data_out,
  output logic            valid_out,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic            almost_empty,
  output logic [AD:0]     count,
  output logic            overflow,
  output logic            underflow
);

  localparam int          c_depth = 2**AD;
  localparam logic [AD:0] c_af_th = AF_TH[AD:0];
  localparam logic [AD:0] c_ae_th = AE_TH[AD:0];
  localparam logic [AD:0] c_one   = {{AD{1'b0}}, 1'b1};

  logic [DATA-1:0] r_mem [0:c_depth-1];
  logic [AD:0]     r_wr_ptr;
  logic [AD:0]     r_rd_ptr;
  logic [AD:0]     r_count;
  logic [DATA-1:0] r_data_out;
  logic            r_valid_out;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AD-1:0] == r_rd_ptr[AD-1:0]) &&
                   (r_wr_ptr[AD] != r_rd_ptr[AD]);

  // A simultaneous read frees the slot, so a full FIFO still takes the write.
  assign w_rd_acc = re & ~w_empty & ~flush;
  assign w_wr_acc = we & ~flush & (~w_full | w_rd_acc);

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AD-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_rd_acc;
      if (w_rd_acc) begin
        r_data_out <= r_mem[r_rd_ptr[AD-1:0]];
        r_rd_ptr   <= r_rd_ptr + c_one;
      end
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_one;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_out     = r_data_out;
  assign valid_out    = r_valid_out;
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign almost_full  = (r_count >= c_af_th);
  assign almost_empty = (r_count <= c_ae_th);

`ifdef RAM_DEMAP_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (we & w_full & ~w_rd_acc) begin
        r_overflow <= 1'b1;
      end
      if (re & w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_demap_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ram_demap_fifo                                               |
// | Brief    : Queue-model bench for ram_demap_fifo (AD=3, AF_TH=6, AE_TH=2)   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ram_demap_fifo;

  localparam int AD    = 3;
  localparam int DATA  = 8;
  localparam int DEPTH = 8;
`ifdef RAM_DEMAP_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic            we = 1'b0;
  logic            re = 1'b0;
  logic [DATA-1:0] data_in = '0;
  logic [DATA-1:0] data_out;
  logic            valid_out, full, empty, almost_full, almost_empty;
  logic [AD:0]     count;
  logic            overflow, underflow;

  int checks = 0;
  int errors = 0;

  ram_demap_fifo #(.AD(AD), .DATA(DATA), .AF_TH(6), .AE_TH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .we(we), .data_in(data_in),
    .re(re), .data_out(data_out), .valid_out(valid_out), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: contents as a plain queue, flags from its size.
  logic [DATA-1:0] q[$];
  logic [DATA-1:0] m_dout = '0;
  bit              m_valid = 0, m_ovf = 0, m_unf = 0;
  bit              rd, wr;

  always @(posedge clk) begin
    if (!reset) begin
      q.delete(); m_dout = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
    end else if (flush) begin
      q.delete(); m_valid = 0; m_ovf = 0; m_unf = 0;
    end else begin
      rd = re && (q.size() != 0);
      wr = we && (q.size() < DEPTH || rd);
      if (we && !wr) m_ovf = 1;
      if (re && q.size() == 0) m_unf = 1;
      m_valid = rd;
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(data_in);
    end
    #1;
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("almost_full", almost_full, q.size() >= 6);
    chk("almost_empty", almost_empty, q.size() <= 2);
    chk("valid_out", valid_out, m_valid);
    chk("data_out", data_out, m_dout);
    chk("overflow", overflow, ERR & m_ovf);
    chk("underflow", underflow, ERR & m_unf);
  end

  task automatic cyc(input bit w, input logic [DATA-1:0] d, input bit r, input bit f);
    @(negedge clk);
    we = w; data_in = d; re = r; flush = f;
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_valid", valid_out, 0);
    @(negedge clk) reset = 1'b1;

    // Three writes 1,0,1 then three reads.
    cyc(1, 8'h01, 0, 0); cyc(1, 8'h00, 0, 0); cyc(1, 8'h01, 0, 0);
    chk("w3_count", count, 3);
    cyc(0, 0, 1, 0); chk("r1_valid", valid_out, 1); chk("r1_data", data_out, 8'h01);
    cyc(0, 0, 1, 0); chk("r2_valid", valid_out, 1); chk("r2_data", data_out, 8'h00);
    cyc(0, 0, 1, 0); chk("r3_valid", valid_out, 1); chk("r3_data", data_out, 8'h01);
    chk("r3_empty", empty, 1);
    cyc(0, 0, 0, 0); chk("idle_valid", valid_out, 0); chk("idle_hold", data_out, 8'h01);

    // Threshold points, then fill and overfill.
    cyc(1, 8'h10, 0, 0); cyc(1, 8'h11, 0, 0);
    chk("c2_ae", almost_empty, 1); chk("c2_af", almost_full, 0);
    cyc(1, 8'h12, 0, 0);
    chk("c3_ae", almost_empty, 0); chk("c3_af", almost_full, 0);
    for (int i = 0; i < 3; i++) cyc(1, 8'h13 + 8'(i), 0, 0);
    chk("c6_ae", almost_empty, 0); chk("c6_af", almost_full, 1);
    cyc(1, 8'h16, 0, 0); cyc(1, 8'h17, 0, 0);
    chk("fill_full", full, 1); chk("fill_count", count, 8);
    cyc(1, 8'hEE, 0, 0);
    chk("ovf_count", count, 8); chk("ovf_flag", overflow, ERR);

    // Sustained read+write while full: oldest word out each cycle.
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'h40 + 8'(i), 1, 0);
      chk("wrap_count", count, 8);
    end
    chk("wrap_last", data_out, 8'h40 + 8'd11);

    // Flush at count 5 with a read pending.
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("pre_flush_count", count, 5);
    cyc(0, 0, 1, 1);
    chk("fl_count", count, 0); chk("fl_empty", empty, 1);
    chk("fl_valid", valid_out, 0); chk("fl_ovf", overflow, 0); chk("fl_unf", underflow, 0);

    // Read+write on empty: no fall-through.
    cyc(1, 8'h5A, 1, 0);
    chk("ew_valid", valid_out, 0); chk("ew_count", count, 1); chk("ew_unf", underflow, ERR);
    cyc(0, 0, 1, 0);
    chk("ew_valid2", valid_out, 1); chk("ew_data", data_out, 8'h5A);

    // Reset asserted while a read is requested.
    cyc(1, 8'h21, 0, 0); cyc(1, 8'h22, 0, 0);
    @(negedge clk);
    we = 0; re = 1; flush = 0;
    #2 reset = 1'b0;
    @(posedge clk); #2;
    chk("mr_valid", valid_out, 0); chk("mr_count", count, 0); chk("mr_data", data_out, 0);
    @(negedge clk);
    reset = 1'b1; re = 0;
    cyc(0, 0, 0, 0);
    chk("mr_after_valid", valid_out, 0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) < 2);
    end
    cyc(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_demap_fifo.md
RAM_DEMAP_FIFO -- requirements
Module: ram_demap_fifo

Interface
REQ-001 SHALL have parameter AD, default 14, address width; depth DEPTH = 2**AD entries.
REQ-002 SHALL have parameter DATA, default 1, word width in bits.
REQ-003 SHALL have parameter AF_TH, default 2**AD-4, almost_full threshold in entries.
REQ-004 SHALL have parameter AE_TH, default 4, almost_empty threshold in entries.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-007 SHALL have port flush  input  1  synchronous clear of all contents.
REQ-008 SHALL have port we  input  1  write request.
REQ-009 SHALL have port data_in  input  DATA  write word.
REQ-010 SHALL have port re  input  1  read request.
REQ-011 SHALL have port data_out  output  DATA  registered read word.
REQ-012 SHALL have port valid_out  output  1  data_out valid, one-cycle pulse per accepted read.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-014 SHALL have port count  output  AD+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL use read and write pointers of AD+1 bits; low AD bits address RAM, MSB is wrap bit.
REQ-017 SHALL assert empty when pointers are equal; full when low bits equal and MSBs differ.
REQ-018 SHALL accept a write when we=1 and (full=0 or an accepted read occurs same cycle); word stored at write pointer, pointer +1.
REQ-019 SHALL accept a read when re=1 and empty=0; data_out and valid_out=1 update on the next rising edge (latency 1).
REQ-020 SHALL hold data_out unchanged and drive valid_out=0 in any cycle following no accepted read.
REQ-021 SHALL, when empty, ignore re even with simultaneous we (no fall-through); written word is readable from the next cycle.
REQ-022 SHALL, when full with re=1 and we=1, accept both; count stays DEPTH.
REQ-023 SHALL update count registered: +1 write only, -1 read only, unchanged for both or neither.
REQ-024 SHALL derive flags from registered count: almost_full = (count >= AF_TH), almost_empty = (count <= AE_TH).
REQ-025 SHALL wrap pointers modulo 2**(AD+1) with no loss of data or flag error across wrap.
REQ-026 SHALL, on flush=1, zero pointers, count, valid_out next edge; flush overrides re/we that cycle; RAM contents and data_out not cleared.
REQ-027 SHALL set overflow on we=1 rejected because full; set underflow on re=1 while empty; both clear only on reset or flush.

Reset
REQ-028 SHALL, on reset low, asynchronously clear pointers, count, data_out, valid_out, overflow, underflow to 0.
REQ-029 SHALL present after reset: empty=1, full=0, almost_empty=1, almost_full=0 (AF_TH>0).
REQ-030 SHALL discard in-flight read on reset mid-operation; no valid_out pulse after release without a new accepted read.
REQ-031 SHALL not reset RAM array contents.

Configuration
REQ-032 SHALL gate error flags with macro RAM_DEMAP_FIFO_ERR_EN.
REQ-033 SHALL, with RAM_DEMAP_FIFO_ERR_EN defined, implement overflow/underflow per REQ-027.
REQ-034 SHALL, without RAM_DEMAP_FIFO_ERR_EN, tie overflow and underflow to constant 0 with no flag logic.

Verification
REQ-035 SHALL cover reset then 3 writes 0x1,0x0,0x1 (DATA=1) then 3 reads -> valid_out pulses on cycles r+1, data 1,0,1, empty=1 after.
REQ-036 SHALL cover AD=3 fill 8 writes -> full=1, count=8; 9th write -> rejected, overflow=1 (ERR_EN), count=8.
REQ-037 SHALL cover AD=3 full with re=1,we=1 for 20 cycles -> count=8 constant, output order matches input order across 2+ pointer wraps.
REQ-038 SHALL cover empty FIFO with re=1,we=1 same cycle -> no valid_out next cycle, count=1, underflow=1 (ERR_EN).
REQ-039 SHALL cover AD=3, AF_TH=6, AE_TH=2: counts 2/3/6 -> almost_empty 1/0/0, almost_full 0/0/1.
REQ-040 SHALL cover flush with count=5 and re=1 -> next cycle count=0, empty=1, valid_out=0, overflow/underflow cleared.
